// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator for a raster pixel stream. Two column-addressed
// line buffers supply the upper rows; windows touching rows/cols 0..1 are suppressed.
module window_gen_3x3 #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_pixel_data,
  input  logic        i_pixel_data_valid,
  output logic [71:0] o_pixel_data,
  output logic        o_pixel_data_valid,
  output logic        o_frame_done
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(2);
  localparam logic [RW-1:0] ROW_MIN  = RW'(2);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  logic [7:0] r_lb0 [IMG_WIDTH];
  logic [7:0] r_lb1 [IMG_WIDTH];
  logic [7:0] r_win [3][3];

  logic [7:0]  w_lb0_rd;
  logic [7:0]  w_lb1_rd;
  logic [7:0]  w_win_nxt [3][3];
  logic [71:0] w_win_flat;
  logic        w_accept;
  logic        w_col_last;
  logic        w_row_last;
  logic        w_win_ok;

  assign w_accept   = i_pixel_data_valid;
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);
  assign w_win_ok   = (r_row >= ROW_MIN) && (r_col >= COL_MIN);

  // Asynchronous read so the old contents are seen before this cycle's write.
  assign w_lb0_rd = r_lb0[r_col];
  assign w_lb1_rd = r_lb1[r_col];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        if (w_row_last) begin
          r_row <= '0;
        end else begin
          r_row <= r_row + ROW_ONE;
        end
      end else begin
        r_col <= r_col + COL_ONE;
      end
    end
  end

  // Line buffer storage carries no reset so it maps onto RAM primitives.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_lb0[r_col] <= w_lb1_rd;
      r_lb1[r_col] <= i_pixel_data;
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_win_nxt[r][0] = r_win[r][1];
      w_win_nxt[r][1] = r_win[r][2];
    end
    w_win_nxt[0][2] = w_lb0_rd;
    w_win_nxt[1][2] = w_lb1_rd;
    w_win_nxt[2][2] = i_pixel_data;
  end

  always_comb begin
    w_win_flat = 72'd0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        w_win_flat[(r*3+k)*8 +: 8] = w_win_nxt[r][k];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int k = 0; k < 3; k++) begin
          r_win[r][k] <= 8'd0;
        end
      end
    end else if (w_accept) begin
      r_win <= w_win_nxt;
    end
  end

  // The last pixel of a frame always completes a window, so done and valid coincide.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pixel_data       <= 72'd0;
      o_pixel_data_valid <= 1'b0;
      o_frame_done       <= 1'b0;
    end else begin
      o_pixel_data_valid <= w_accept && w_win_ok;
      o_frame_done       <= w_accept && w_row_last && w_col_last;
      if (w_accept && w_win_ok) begin
        o_pixel_data <= w_win_flat;
      end
    end
  end

endmodule
